// File: rtl/inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// inv_sub_bytes_iter : iterative AES InvSubBytes, COLS_PER_CYCLE columns/clock;
// optional forward S-box mode enabled by macro INV_SUB_FWD_EN.   Revision 1.0
// ============================================================================
module inv_sub_bytes_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Sub_En,
`ifdef INV_SUB_FWD_EN
    input  logic         Fwd,
`endif
    input  logic [127:0] Text,
    output logic [127:0] Modified_Text,
    output logic         Sub_Ry
);

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols
        $error("inv_sub_bytes_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         C_NPASS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] C_LAST  = 2'(C_NPASS - 1);

    // Byte k of each table sits at bits [8k +: 8] (ascending range).
    localparam logic [0:2047] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

`ifdef INV_SUB_FWD_EN
    localparam logic [0:2047] C_FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic mode_q, mode_d;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   mod_q, mod_d;
    logic           ry_q, ry_d;
    logic [127:0]   w_sub;
    logic [127:0]   w_pass;

    for (genvar b = 0; b < 16; b++) begin : g_byte
        logic [7:0] w_byte;
        assign w_byte = work_q[127-8*b -: 8];
`ifdef INV_SUB_FWD_EN
        assign w_sub[127-8*b -: 8] = mode_q ? C_FWD_SBOX[{w_byte, 3'b000} +: 8]
                                            : C_INV_SBOX[{w_byte, 3'b000} +: 8];
`else
        assign w_sub[127-8*b -: 8] = C_INV_SBOX[{w_byte, 3'b000} +: 8];
`endif
    end

    // Only the column group selected by the pass counter is replaced.
    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam logic [1:0] C_PASS = 2'(c / COLS_PER_CYCLE);
        assign w_pass[127-32*c -: 32] = (cnt_q == C_PASS) ? w_sub[127-32*c -: 32]
                                                          : work_q[127-32*c -: 32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mod_d   = mod_q;
        ry_d    = ry_q;
`ifdef INV_SUB_FWD_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                ry_d = 1'b0;
                if (Sub_En) begin
                    work_d  = Text;
                    cnt_d   = 2'd0;
                    state_d = S_BUSY;
`ifdef INV_SUB_FWD_EN
                    mode_d  = Fwd;
`endif
                end
            end
            S_BUSY: begin
                if (!Sub_En) begin
                    ry_d    = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    work_d = w_pass;
                    if (cnt_q == C_LAST) begin
                        mod_d   = w_pass;
                        ry_d    = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (!Sub_En) begin
                    ry_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ry_d    = 1'b0;
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            work_q  <= 128'd0;
            mod_q   <= 128'd0;
            ry_q    <= 1'b0;
`ifdef INV_SUB_FWD_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mod_q   <= mod_d;
            ry_q    <= ry_d;
`ifdef INV_SUB_FWD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign Modified_Text = mod_q;
    assign Sub_Ry        = ry_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_inv_sub_bytes_iter : scoreboard bench for inv_sub_bytes_iter (directed
// FIPS-197 and boundary vectors; Fwd cases when INV_SUB_FWD_EN).   Revision 1.0
// ============================================================================
module tb_inv_sub_bytes_iter;

    parameter int COLS_PER_CYCLE = 1;
    localparam int C_N = 4 / COLS_PER_CYCLE;

    localparam logic [127:0] C_FIPS_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] C_FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] C_ALL00    = {16{8'h00}};
    localparam logic [127:0] C_ALL52    = {16{8'h52}};
    localparam logic [127:0] C_ALL53    = {16{8'h53}};
    localparam logic [127:0] C_ALL63    = {16{8'h63}};
    localparam logic [127:0] C_ALL7D    = {16{8'h7d}};
    localparam logic [127:0] C_ALLED    = {16{8'hed}};
    localparam logic [127:0] C_ALLFF    = {16{8'hff}};

    logic         Clk    = 1'b0;
    logic         Rst_n  = 1'b0;
    logic         Sub_En = 1'b0;
    logic         Fwd    = 1'b0;
    logic [127:0] Text   = 128'd0;
    logic [127:0] Modified_Text, mt2, mt4;
    logic         Sub_Ry, ry2, ry4;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;
    logic         prev_ry = 1'b0;

    always #5 Clk = ~Clk;

    inv_sub_bytes_iter #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Sub_En(Sub_En),
`ifdef INV_SUB_FWD_EN
        .Fwd(Fwd),
`endif
        .Text(Text), .Modified_Text(Modified_Text), .Sub_Ry(Sub_Ry)
    );

    inv_sub_bytes_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Sub_En(Sub_En),
`ifdef INV_SUB_FWD_EN
        .Fwd(Fwd),
`endif
        .Text(Text), .Modified_Text(mt2), .Sub_Ry(ry2)
    );

    inv_sub_bytes_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Sub_En(Sub_En),
`ifdef INV_SUB_FWD_EN
        .Fwd(Fwd),
`endif
        .Text(Text), .Modified_Text(mt4), .Sub_Ry(ry4)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising Sub_Ry must match the oldest expected result.
    always @(negedge Clk) begin
        if (Sub_Ry && !prev_ry) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: Sub_Ry rose with nothing expected, data %h", Modified_Text);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_data", Modified_Text, mon_exp);
            end
        end
        prev_ry = Sub_Ry;
    end

    // Called just after a rising edge; the following edge is the capture edge.
    task automatic start_op(input logic [127:0] txt, input logic fwd_v,
                            input logic [127:0] exp, input bit push);
        Text   = txt;
        Fwd    = fwd_v;
        Sub_En = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge Clk); #1;
        chk("ry_low_after_capture", 128'(Sub_Ry), 128'd0);
    endtask

    task automatic wait_done(input logic [127:0] exp);
        int  lat_m = 0;
        int  lat_2 = 0;
        int  lat_4 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk); #1;
            if (lat_m == 0 && Sub_Ry) lat_m = k;
            if (lat_2 == 0 && ry2) begin
                lat_2 = k;
                chk("data_c2", mt2, exp);
            end
            if (lat_4 == 0 && ry4) begin
                lat_4 = k;
                chk("data_c4", mt4, exp);
            end
            if (lat_m != 0 && lat_2 != 0 && lat_4 != 0) break;
        end
        chk("latency_main", 128'(lat_m), 128'(C_N));
        chk("latency_c2", 128'(lat_2), 128'd2);
        chk("latency_c4", 128'(lat_4), 128'd1);
    endtask

    task automatic hold_release(input logic [127:0] exp);
        Text = ~Text;
        repeat (2) begin @(posedge Clk); #1; end
        chk("hold_ry", 128'(Sub_Ry), 128'd1);
        chk("hold_data", Modified_Text, exp);
        Sub_En = 1'b0;
        @(posedge Clk); #1;
        chk("release_ry", 128'(Sub_Ry), 128'd0);
        chk("release_data", Modified_Text, exp);
    endtask

    task automatic full_op(input logic [127:0] txt, input logic fwd_v, input logic [127:0] exp);
        start_op(txt, fwd_v, exp, 1'b1);
        wait_done(exp);
        hold_release(exp);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_ry", 128'(Sub_Ry), 128'd0);
        chk("reset_data", Modified_Text, 128'd0);
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("idle_ry", 128'(Sub_Ry), 128'd0);
            chk("idle_data", Modified_Text, 128'd0);
        end

        full_op(C_FIPS_IN, 1'b0, C_FIPS_OUT);
        full_op(C_ALL63, 1'b0, C_ALL00);
        full_op(C_ALL00, 1'b0, C_ALL52);
        full_op(C_ALLFF, 1'b0, C_ALL7D);

        // Abort while BUSY: result register must keep the previous value.
        start_op(C_ALL00, 1'b0, 128'd0, 1'b0);
        if (C_N >= 2) begin @(posedge Clk); #1; end
        Sub_En = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            chk("abort_ry", 128'(Sub_Ry), 128'd0);
        end
        chk("abort_data", Modified_Text, C_ALL7D);
        full_op(C_ALL00, 1'b0, C_ALL52);

        // Asynchronous reset in BUSY, away from any clock edge.
        start_op(C_FIPS_IN, 1'b0, 128'd0, 1'b0);
        #1 Rst_n = 1'b0;
        #1;
        chk("rst_busy_ry", 128'(Sub_Ry), 128'd0);
        chk("rst_busy_data", Modified_Text, 128'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        full_op(C_FIPS_IN, 1'b0, C_FIPS_OUT);

        // Asynchronous reset in DONE.
        start_op(C_ALL63, 1'b0, C_ALL00, 1'b1);
        wait_done(C_ALL00);
        @(negedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        chk("rst_done_ry", 128'(Sub_Ry), 128'd0);
        chk("rst_done_data", Modified_Text, 128'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        full_op(C_ALLFF, 1'b0, C_ALL7D);

`ifdef INV_SUB_FWD_EN
        full_op(C_ALL00, 1'b1, C_ALL63);
        full_op(C_ALL53, 1'b1, C_ALLED);
        // Fwd is only sampled at capture; toggling it afterwards is ignored.
        start_op(C_FIPS_IN, 1'b0, C_FIPS_OUT, 1'b1);
        Fwd = 1'b1;
        wait_done(C_FIPS_OUT);
        hold_release(C_FIPS_OUT);
        start_op(C_ALL00, 1'b1, C_ALL63, 1'b1);
        Fwd = 1'b0;
        wait_done(C_ALL63);
        hold_release(C_ALL63);
`endif

        repeat (2) @(posedge Clk);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
